// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle controller and the datapath muxes it
// drives: opcode map, FSM state encoding, write-back / PC / ALU select codes.
package cpu_ctrl_pkg;

  // Opcode field instr[7:5]
  typedef enum logic [2:0] {
    OP_ALUR = 3'b000,
    OP_ADDI = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_LI   = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // Write-back mux select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  // PC source mux select
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // Opcodes whose EXEC step uses the immediate as ALU operand B
  function automatic logic uses_imm(input opcode_e op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the wait reaches
// MEM_TIMEOUT.
// Ports:
//   clock   in  1  system clock, rising edge
//   reset   in  1  asynchronous active-low reset
//   clear   in  1  zero the count (asserted on every FSM state change)
//   enable  in  1  a memory request is outstanding and not yet answered
//   expired out 1  count has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign expired = (count_q == 8'(MEM_TIMEOUT));

  // Count holds at MEM_TIMEOUT so a stalled compare never wraps past it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the 8-bit MIPS-style multicycle datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the PC, IR, ALU,
// memory handshake and write-back controls, counts retired instructions and
// traps memory timeouts into an absorbing ERR state.
// Ports:
//   clock      in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   run        in   1      execute enable, sampled in IDLE and at retire
//   instr      in   8      IR contents, opcode in [7:5], valid from DECODE
//   zero       in   1      ALU zero flag, used by BEQ in EXEC
//   mem_ready  in   1      memory read data valid / write accepted
//   pc_write   out  1      PC load enable
//   pc_src     out  2      PC_INC / PC_BR / PC_JMP
//   ir_write   out  1      IR load enable
//   mem_req    out  1      memory request, held until mem_ready
//   mem_we     out  1      write qualifier for mem_req
//   alu_op     out  2      ALU_ADD / ALU_SUB / ALU_FUNCT
//   alu_src    out  1      0 = register B, 1 = immediate
//   reg_write  out  1      register file write enable
//   wb_sel     out  2      WB_ALU / WB_MEM / WB_IMM
//   halted     out  1      FSM in HALT
//   error      out  1      FSM in ERR
//   retired    out  CNT_W  retired-instruction count (wraps)
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  opcode_e          op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  opcode_e dec_op;
  logic    retire;       // instruction completes this cycle
  logic    seq_next;     // leave for FETCH/IDLE depending on run
  logic    mem_wait;     // request outstanding, no answer this cycle
  logic    tmr_expired;
  logic    instr_unused;

  assign dec_op       = opcode_e'(instr[7:5]);
  assign instr_unused = ^instr[4:0];
  assign mem_wait     = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign retired      = retired_q;

  // Every state change clears the timer, so FETCH and MEM always start at 0
  // (including SW MEM -> FETCH back to back).
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (mem_wait),
    .expired (tmr_expired)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire   = 1'b0;
    seq_next = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      // mem_ready beats the timeout when both happen in the same cycle
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_DECODE;
        else if (tmr_expired) state_d = ST_ERR;
      end

      ST_DECODE: begin
        op_d = dec_op;
        case (dec_op)
          OP_LI:   state_d = ST_WB;
          OP_JMP:  begin retire = 1'b1; seq_next = 1'b1; end
          OP_HALT: begin retire = 1'b1; state_d = ST_HALT; end
          default: state_d = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        case (op_q)
          OP_BEQ:       begin retire = 1'b1; seq_next = 1'b1; end
          OP_LW, OP_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire   = 1'b1;
            seq_next = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        retire   = 1'b1;
        seq_next = 1'b1;
      end

      default: state_d = state_q;  // HALT, ERR absorb until reset
    endcase

    if (seq_next) state_d = run ? ST_FETCH : ST_IDLE;

    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ALUR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Output decode. Only ir_write/pc_write in FETCH (mem_ready), the DECODE
  // jump (opcode not yet latched) and the BEQ pc_write (zero) look past
  // state_q/op_q; run never reaches an output.
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = PC_INC;
    ir_write  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    halted    = 1'b0;
    error     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        pc_src   = PC_INC;
      end

      ST_DECODE: begin
        if (dec_op == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
        end
      end

      ST_EXEC: begin
        alu_src = uses_imm(op_q);
        if (op_q == OP_ALUR)     alu_op = ALU_FUNCT;
        else if (op_q == OP_BEQ) alu_op = ALU_SUB;
        else                     alu_op = ALU_ADD;
        if (op_q == OP_BEQ) begin
          pc_write = zero;
          pc_src   = PC_BR;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
      end

      ST_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_LW)      wb_sel = WB_MEM;
        else if (op_q == OP_LI) wb_sel = WB_IMM;
        else                    wb_sel = WB_ALU;
      end

      ST_HALT: halted = 1'b1;
      ST_ERR:  error  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Retire counts go through a scoreboard
// queue: pushed when an instruction is issued, popped when it retires. A
// second instance with a 4-bit counter shares all inputs to show wrap-around.
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] instr = 8'h00;

  logic        pc_write, ir_write, mem_req, mem_we, alu_src, reg_write, halted, error;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic [15:0] retired;

  logic        pc_write_s, ir_write_s, mem_req_s, mem_we_s, alu_src_s, reg_write_s, halted_s, error_s;
  logic [1:0]  pc_src_s, alu_op_s, wb_sel_s;
  logic [3:0]  retired_s;

  logic [13:0] ov;
  assign ov = {pc_write, pc_src, ir_write, mem_req, mem_we, alu_op, alu_src,
               reg_write, wb_sel, halted, error};

  always #5 clock = ~clock;

  multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .error(error), .retired(retired)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) u_dut_s (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write_s), .pc_src(pc_src_s),
    .ir_write(ir_write_s), .mem_req(mem_req_s), .mem_we(mem_we_s), .alu_op(alu_op_s),
    .alu_src(alu_src_s), .reg_write(reg_write_s), .wb_sel(wb_sel_s),
    .halted(halted_s), .error(error_s), .retired(retired_s)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_cnt = 16'd0;

  // {pc_write, pc_src, ir_write, mem_req, mem_we, alu_op, alu_src, reg_write, wb_sel, halted, error}
  function automatic logic [13:0] ex(input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic mrq, input logic mwe,
                                     input logic [1:0] aop, input logic asrc,
                                     input logic rw, input logic [1:0] wbs,
                                     input logic hlt, input logic err);
    return {pcw, pcs, irw, mrq, mwe, aop, asrc, rw, wbs, hlt, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic issue();
    model_cnt = model_cnt + 16'd1;
    exp_q.push_back(model_cnt);
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_sb observed=retire expected=none_pending", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_retired"}, 32'(retired), 32'(e));
      chk({tag, "_retired_w4"}, 32'(retired_s), 32'(e[3:0]));
      $display("retire %s: retired=%0h w4=%0h", tag, retired, retired_s);
    end
  endtask

  logic [13:0] F_RDY, F_WAIT;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    F_RDY  = ex(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    F_WAIT = ex(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Reset state
    nxt(); nxt();
    chk("rst_outs", 32'(ov), 0);
    chk("rst_retired", 32'(retired), 0);
    reset = 1'b1;
    nxt();
    chk("idle_hold", 32'(ov), 0);

    // Asynchronous reset in the middle of a stalled fetch
    run = 1'b1; mem_ready = 1'b0;
    nxt();
    chk("fetch_wait", 32'(ov), 32'(F_WAIT));
    reset = 1'b0; run = 1'b0;
    #1;
    chk("async_rst_memreq", 32'(mem_req), 0);
    chk("async_rst_outs", 32'(ov), 0);
    nxt();
    reset = 1'b1;
    nxt();
    chk("post_rst_idle", 32'(ov), 0);

    // ALU-R, zero-wait memory
    instr = 8'b000_10101; mem_ready = 1'b1; issue();
    run = 1'b1; nxt(); run = 1'b0;
    chk("alur_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("alur_decode", 32'(ov), 0);
    nxt(); chk("alur_exec", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd2, 0, 0, 2'd0, 0, 0)));
    nxt(); chk("alur_wb", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 0)));
    nxt(); sb_check("alur"); chk("alur_idle", 32'(ov), 0);

    // LW with three wait cycles in MEM: cycles F D E M M M M WB
    instr = 8'b010_00011; mem_ready = 1'b1; issue();
    run = 1'b1; nxt(); run = 1'b0;
    chk("lw_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("lw_decode", 32'(ov), 0);
    mem_ready = 1'b0;
    nxt(); chk("lw_exec", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0)));
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (i == 3) begin mem_ready = 1'b1; #1; end
      chk("lw_mem", 32'(ov), 32'(ex(0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 0)));
    end
    nxt(); chk("lw_wb_cycle8", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd1, 0, 0)));
    nxt(); sb_check("lw");

    // LI: write-back of the immediate in cycle 3
    instr = 8'b101_00010; issue();
    run = 1'b1; nxt(); run = 1'b0;
    chk("li_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("li_decode", 32'(ov), 0);
    nxt(); chk("li_wb", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd2, 0, 0)));
    nxt(); sb_check("li");

    // BEQ not taken then taken
    for (int z = 0; z < 2; z++) begin
      instr = 8'b100_00000; issue();
      run = 1'b1; nxt(); run = 1'b0;
      chk("beq_fetch", 32'(ov), 32'(F_RDY));
      nxt(); chk("beq_decode", 32'(ov), 0);
      zero = (z == 1);
      nxt(); chk(z == 1 ? "beq_taken" : "beq_not_taken", 32'(ov),
                 32'(ex(z == 1, 2'd1, 0, 0, 0, 2'd1, 0, 0, 2'd0, 0, 0)));
      nxt(); sb_check("beq");
    end
    zero = 1'b0;

    // JMP retires from DECODE
    instr = 8'b110_00000; issue();
    run = 1'b1; nxt(); run = 1'b0;
    chk("jmp_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("jmp_decode", 32'(ov), 32'(ex(1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0)));
    nxt(); sb_check("jmp");

    // ADDI
    instr = 8'b001_00001; issue();
    run = 1'b1; nxt(); run = 1'b0;
    chk("addi_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("addi_decode", 32'(ov), 0);
    nxt(); chk("addi_exec", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0)));
    nxt(); chk("addi_wb", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd0, 0, 0)));
    nxt(); sb_check("addi");

    // SW with run dropped during EXEC: completes, then IDLE
    instr = 8'b011_00000; issue();
    run = 1'b1;
    nxt(); chk("sw_fetch", 32'(ov), 32'(F_RDY));
    nxt(); chk("sw_decode", 32'(ov), 0);
    nxt(); chk("sw_exec", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0)));
    run = 1'b0;
    nxt(); chk("sw_mem", 32'(ov), 32'(ex(0, 0, 0, 1, 1, 2'd0, 0, 0, 2'd0, 0, 0)));
    nxt(); sb_check("sw"); chk("sw_idle", 32'(ov), 0);
    nxt(); chk("sw_idle_hold", 32'(ov), 0);

    // Back-to-back JMPs with run held: 2 cycles each, narrow counter wraps
    instr = 8'b110_00000; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt();
      if (i > 0) sb_check("jmp_stream");
      chk("jmps_fetch", 32'(ov), 32'(F_RDY));
      issue();
      nxt();
      chk("jmps_decode", 32'(ov), 32'(ex(1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0)));
      if (i == 9) run = 1'b0;
    end
    nxt(); sb_check("jmp_stream_end"); chk("jmps_idle", 32'(ov), 0);

    // Fetch timeout: mem_ready stuck low
    run = 1'b1; mem_ready = 1'b0;
    nxt(); chk("to_wait0", 32'(ov), 32'(F_WAIT));
    for (int i = 1; i <= 8; i++) begin
      nxt(); chk("to_wait", 32'(ov), 32'(F_WAIT));
    end
    nxt(); chk("to_err", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1)));
    mem_ready = 1'b1;
    nxt(); chk("to_err_hold", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1)));
    chk("to_retired_kept", 32'(retired), 32'(model_cnt));

    // Reset out of ERR clears the counter
    reset = 1'b0; run = 1'b0;
    #1;
    chk("err_rst_outs", 32'(ov), 0);
    chk("err_rst_retired", 32'(retired), 0);
    chk("err_rst_retired_w4", 32'(retired_s), 0);
    model_cnt = 16'd0;
    nxt();
    reset = 1'b1;
    nxt();

    // mem_ready exactly when the wait count reaches 8 wins, then HALT
    instr = 8'b111_00000; mem_ready = 1'b0; run = 1'b1;
    nxt(); chk("edge_wait0", 32'(ov), 32'(F_WAIT));
    for (int i = 1; i <= 8; i++) begin
      nxt();
      if (i == 8) begin
        mem_ready = 1'b1; #1;
        chk("edge_ready_at_8", 32'(ov), 32'(F_RDY));
      end else begin
        chk("edge_wait", 32'(ov), 32'(F_WAIT));
      end
    end
    issue();
    nxt(); chk("edge_decode", 32'(ov), 0);
    nxt(); chk("halt", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0)));
    sb_check("halt");
    for (int i = 0; i < 3; i++) begin
      nxt(); chk("halt_hold", 32'(ov), 32'(ex(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0)));
    end
    chk("halt_retired_hold", 32'(retired), 32'(model_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
